// File: rtl/alu_pkg.sv
// Shared ALU package: datapath width, divider state encoding and divide-by-zero constant.
package alu_pkg;

   localparam int unsigned ALU_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   localparam logic [ALU_W-1:0] DIV_ZERO_QUOT = {ALU_W{1'b1}};

endpackage

// File: rtl/seq_divider_32_if.sv
// Operand/result handshake bundle between the ALU issue logic and the sequential divider.
interface seq_divider_32_if #(
   parameter int unsigned N = alu_pkg::ALU_W
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero
   );
endinterface

// File: rtl/seq_divider_32_step.sv
// One restoring-division iteration built on the shared add/sub in subtract mode.
module alu_addsub #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] sum,
   output logic         cout
);
   localparam int unsigned WC = W + 1;

   // sel=1 gives a + ~b + 1; carry-out set means a >= b
   assign {cout, sum} = WC'(a) + WC'(b ^ {W{sel}}) + WC'(sel);
endmodule

module div_restore_step #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] rem_in,
   input  logic         bit_in,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_out,
   output logic         q_bit
);
   localparam int unsigned W = N + 1;

   logic [W-1:0] trial_a;
   logic [W-1:0] trial_b;
   logic [W-1:0] trial;
   logic         cout;

   assign trial_a = {rem_in, bit_in};
   assign trial_b = {1'b0, divisor};

   alu_addsub #(.W(W)) u_addsub (
      .a    (trial_a),
      .b    (trial_b),
      .sel  (1'b1),
      .sum  (trial),
      .cout (cout)
   );

   // A non-negative trial always fits in N bits since the incoming remainder is below the divisor
   assign q_bit   = cout & ~trial[N];
   assign rem_out = q_bit ? trial[N-1:0] : trial_a[N-1:0];
endmodule

// File: rtl/seq_divider_32.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional two's-complement operation when SEQ_DIV_SIGNED_EN is defined.
module seq_divider_32
   import alu_pkg::*;
#(
   parameter int unsigned N = ALU_W
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_divider_32_if.slave bus
);
   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   div_state_e   state, state_next;
   logic [CW-1:0] count, count_next;
   logic [N-1:0] r_q, r_next, q_q, q_next, d_q, d_next;
   logic         dz_q, dz_next;
   logic         in_ready_q, in_ready_next;
   logic         out_valid_q, out_valid_next;
   logic [N-1:0] quot_q, quot_next, rem_q, rem_next;
   logic         div_zero_q, div_zero_next;
   logic [N-1:0] step_rem;
   logic         step_bit;
   logic         accept;
`ifdef SEQ_DIV_SIGNED_EN
   logic         neg_q_q, neg_q_next, neg_r_q, neg_r_next;

   function automatic logic [N-1:0] neg_if(input logic [N-1:0] x, input logic neg);
      return neg ? (~x + N'(1)) : x;
   endfunction
`endif

   div_restore_step #(.N(N)) u_step (
      .rem_in  (r_q),
      .bit_in  (q_q[N-1]),
      .divisor (d_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign accept = bus.in_valid && in_ready_q;

   // Next-state and datapath loads
   always_comb begin
      state_next     = state;
      count_next     = count;
      r_next         = r_q;
      q_next         = q_q;
      d_next         = d_q;
      dz_next        = dz_q;
      out_valid_next = out_valid_q;
      quot_next      = quot_q;
      rem_next       = rem_q;
      div_zero_next  = div_zero_q;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q_next     = neg_q_q;
      neg_r_next     = neg_r_q;
`endif
      case (state)
         ST_IDLE: begin
            if (accept) begin
               r_next     = '0;
               count_next = '0;
               dz_next    = (bus.divisor == '0);
`ifdef SEQ_DIV_SIGNED_EN
               q_next     = neg_if(bus.dividend, bus.dividend[N-1]);
               d_next     = neg_if(bus.divisor, bus.divisor[N-1]);
               neg_q_next = bus.dividend[N-1] ^ bus.divisor[N-1];
               neg_r_next = bus.dividend[N-1];
`else
               q_next     = bus.dividend;
               d_next     = bus.divisor;
`endif
               state_next = (bus.divisor == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            r_next     = step_rem;
            q_next     = {q_q[N-2:0], step_bit};
            count_next = count + CW'(1);
            if (count == LAST) begin
               count_next = '0;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!out_valid_q) begin
               out_valid_next = 1'b1;
               div_zero_next  = dz_q;
`ifdef SEQ_DIV_SIGNED_EN
               quot_next      = dz_q ? N'(DIV_ZERO_QUOT) : neg_if(q_q, neg_q_q);
               rem_next       = dz_q ? neg_if(q_q, neg_r_q) : neg_if(r_q, neg_r_q);
`else
               quot_next      = dz_q ? N'(DIV_ZERO_QUOT) : q_q;
               rem_next       = dz_q ? q_q : r_q;
`endif
            end else if (bus.out_ready) begin
               out_valid_next = 1'b0;
               state_next     = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      in_ready_next = (state_next == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         div_zero_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         count       <= count_next;
         r_q         <= r_next;
         q_q         <= q_next;
         d_q         <= d_next;
         dz_q        <= dz_next;
         in_ready_q  <= in_ready_next;
         out_valid_q <= out_valid_next;
         quot_q      <= quot_next;
         rem_q       <= rem_next;
         div_zero_q  <= div_zero_next;
`ifdef SEQ_DIV_SIGNED_EN
         neg_q_q     <= neg_q_next;
         neg_r_q     <= neg_r_next;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: latency, results, divide-by-zero, back-pressure, mid-op reset.
// Signed vectors are added when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider_32;
   import alu_pkg::*;

   localparam int unsigned N = ALU_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   seq_divider_32_if #(.N(N)) bus ();

   seq_divider_32 #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one division, check latency/busy/results, optionally stall the consumer
   task automatic run_div(input string tag, input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                          input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                          input logic exp_dz, input int exp_lat, input int hold);
      int   lat;
      int   waited;
      logic busy_ok;
      logic stable_ok;
      logic [N-1:0] q_cap;
      logic [N-1:0] r_cap;
      waited = 0;
      while (!bus.in_ready && waited < 50) begin
         tick();
         waited++;
      end
      chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
      bus.dividend  = dvd;
      bus.divisor   = dvs;
      bus.out_ready = (hold == 0);
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) busy_ok = 1'b0;
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
      chk({tag, "_quot"}, 64'(bus.quotient), 64'(exp_q));
      chk({tag, "_rem"}, 64'(bus.remainder), 64'(exp_r));
      chk({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
      if (hold > 0) begin
         q_cap = bus.quotient;
         r_cap = bus.remainder;
         stable_ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            if (!bus.out_valid || bus.in_ready || bus.quotient !== q_cap ||
                bus.remainder !== r_cap)
               stable_ok = 1'b0;
         end
         chk({tag, "_bp_stable"}, 64'(stable_ok), 64'd1);
         bus.out_ready = 1'b1;
      end
      tick();
      chk({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_post_ready"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_quot", 64'(bus.quotient), 64'd0);
      chk("rst_rem", 64'(bus.remainder), 64'd0);
      chk("rst_dz", 64'(bus.div_zero), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

      run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
      run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0);
      run_div("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33, 0);
      run_div("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0);
      run_div("bp200_10", 32'd200, 32'd10, 32'd20, 32'd0, 1'b0, 33, 10);
      run_div("after_bp", 32'd77, 32'd8, 32'd9, 32'd5, 1'b0, 33, 0);

      // Reset in the middle of a running 1000/3
      bus.dividend = 32'd1000;
      bus.divisor  = 32'd3;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_quot", 64'(bus.quotient), 64'd0);
      chk("mid_rst_rem", 64'(bus.remainder), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
      chk("mid_rst_valid2", 64'(bus.out_valid), 64'd0);
      run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

`ifdef SEQ_DIV_SIGNED_EN
      run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
      run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0);
      run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
      run_div("s_m9_0", 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
